// File: rtl/data_memory_ws.sv
// Wait-stated big-endian data memory with a request/ready handshake.
// One access in flight; misaligned and out-of-range requests complete at once with a fault.
module data_memory_ws #(
  parameter int DEPTH_WORDS = 8192,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_lscontrol,
  input  logic        i_sign_extend,
  input  logic [31:0] i_address,
  input  logic [31:0] i_writedata,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_readdata
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_count;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_sext;
  logic [1:0]         r_offset;
  logic [IDX_W-1:0]   r_index;
  logic [31:0]        r_wdata;
  logic               r_fault;
  logic [31:0]        r_readdata;
  logic [31:0]        r_rd_word;
  logic [3:0][7:0]    r_mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_reject;
  logic               w_misaligned;
  logic               w_out_of_range;
  logic               w_commit;
  logic [IDX_W-1:0]   w_req_index;
  logic [3:0]         w_byte_en;
  logic [31:0]        w_store_lanes;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load_value;

  assign o_ready    = (r_state != ST_WAIT);
  assign o_done     = (r_state == ST_DONE);
  assign o_fault    = o_done & r_fault;
  assign o_readdata = r_readdata;

  assign w_accept       = o_ready & i_req;
  assign w_misaligned   = ((i_lscontrol == 2'd1) && i_address[0]) ||
                          (i_lscontrol[1] && (i_address[1:0] != 2'b00));
  assign w_out_of_range = ({2'b00, i_address[31:2]} >= 32'(DEPTH_WORDS));
  assign w_reject       = w_misaligned | w_out_of_range;
  assign w_req_index    = i_address[IDX_W+1:2];
  assign w_commit       = (r_state == ST_WAIT) && (r_count == 4'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_next = w_reject ? ST_DONE : ST_WAIT;
        else          w_state_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (r_count == 4'd0) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Address byte 0 is the most significant lane of the word.
  always_comb begin
    w_byte_en     = 4'b1111;
    w_store_lanes = r_wdata;
    case (r_size)
      2'd0: begin
        w_byte_en     = 4'b1000 >> r_offset;
        w_store_lanes = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_byte_en     = r_offset[1] ? 4'b0011 : 4'b1100;
        w_store_lanes = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = r_rd_word[31:24];
    case (r_offset)
      2'd1:    w_byte = r_rd_word[23:16];
      2'd2:    w_byte = r_rd_word[15:8];
      2'd3:    w_byte = r_rd_word[7:0];
      default: w_byte = r_rd_word[31:24];
    endcase
    w_half = r_offset[1] ? r_rd_word[15:0] : r_rd_word[31:16];
    case (r_size)
      2'd0:    w_load_value = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_load_value = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load_value = r_rd_word;
    endcase
  end

  // The word is read at accept so it is ready by commit, even with zero wait cycles.
  always_ff @(posedge i_clock) begin
    if (w_commit && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) r_mem[r_index][b] <= w_store_lanes[b*8 +: 8];
      end
    end
    if (w_accept) r_rd_word <= r_mem[w_req_index];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_count    <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_sext     <= 1'b0;
      r_offset   <= 2'd0;
      r_index    <= '0;
      r_wdata    <= 32'd0;
      r_fault    <= 1'b0;
      r_readdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we     <= i_we;
        r_size   <= i_lscontrol;
        r_sext   <= i_sign_extend;
        r_offset <= i_address[1:0];
        r_index  <= w_req_index;
        r_wdata  <= i_writedata;
        r_count  <= 4'(WAIT_CYCLES);
        r_fault  <= w_reject;
        if (w_reject) r_readdata <= 32'd0;
      end else if (r_state == ST_WAIT) begin
        if (r_count != 4'd0)  r_count    <= r_count - 4'd1;
        else if (!r_we)       r_readdata <= w_load_value;
      end
    end
  end

endmodule
